// File: rtl/pipe_control_unit.sv
// pipe_control_unit: registered MIPS ID-stage control decode with
// stall/flush handling, MULT/DIV busy tracking and SYSCALL drain handshake.
module pipe_control_unit #(
    parameter int ALUOP_W     = 3,
    parameter int MDU_LAT     = 4,
    parameter int DRAIN_DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               instr_valid,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic               syscall_ack,
    output logic [ALUOP_W+1:0] EX_D,
    output logic [1:0]         MEM_D,
    output logic [1:0]         WB_D,
    output logic               jump,
    output logic               branch,
    output logic               jr_control,
    output logic               jal_control,
    output logic               stall_out,
    output logic               syscall_req,
    output logic               mdu_busy,
    output logic               illegal_instr
);

    localparam int MCW = $clog2(MDU_LAT + 1);
    localparam int DCW = $clog2(DRAIN_DEPTH + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_NOP     = 6'h00;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [1:0] {
        IDLE,
        SYS_DRAIN,
        SYS_WAIT
    } state_t;

    state_t           state;
    logic [DCW-1:0]   drain_cnt;
    logic [MCW-1:0]   mdu_cnt;
    logic             sys_done;

    logic [5:0] op;
    logic [5:0] fn;
    logic       d_regdst;
    logic       d_alusrc;
    logic [2:0] d_alu;
    logic       d_memwr;
    logic       d_memrd;
    logic       d_regwr;
    logic       d_memtoreg;
    logic       d_jump;
    logic       d_branch;
    logic       d_jr;
    logic       d_jal;
    logic       d_ok;
    logic       is_mdu;
    logic       is_mf;
    logic       is_sys;

    logic       mdu_hazard;
    logic       sys_enter;
    logic       take;
    logic       mdu_start;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    // Opcode/funct decode into the raw control bundle
    always_comb begin
        d_regdst   = 1'b0;
        d_alusrc   = 1'b0;
        d_alu      = 3'd0;
        d_memwr    = 1'b0;
        d_memrd    = 1'b0;
        d_regwr    = 1'b0;
        d_memtoreg = 1'b0;
        d_jump     = 1'b0;
        d_branch   = 1'b0;
        d_jr       = 1'b0;
        d_jal      = 1'b0;
        d_ok       = 1'b1;
        is_mdu     = 1'b0;
        is_mf      = 1'b0;
        is_sys     = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADD: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        d_alu    = 3'd2;
                    end
                    FN_SUB: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        d_alu    = 3'd6;
                    end
                    FN_AND: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        d_alu    = 3'd0;
                    end
                    FN_OR: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        d_alu    = 3'd1;
                    end
                    FN_SLT: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        d_alu    = 3'd7;
                    end
                    FN_JR: begin
                        d_jump = 1'b1;
                        d_jr   = 1'b1;
                    end
                    FN_NOP: begin
                    end
                    FN_MULT, FN_DIV: begin
                        is_mdu = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        d_regdst = 1'b1;
                        d_regwr  = 1'b1;
                        is_mf    = 1'b1;
                    end
                    FN_SYSCALL: begin
                        is_sys = 1'b1;
                    end
                    default: d_ok = 1'b0;
                endcase
            end
            OP_LUI: begin
                d_regwr  = 1'b1;
                d_alusrc = 1'b1;
                d_alu    = 3'd3;
            end
            OP_ADDI, OP_ADDIU: begin
                d_regwr  = 1'b1;
                d_alusrc = 1'b1;
                d_alu    = 3'd2;
            end
            OP_ORI: begin
                d_regwr  = 1'b1;
                d_alusrc = 1'b1;
                d_alu    = 3'd1;
            end
            OP_BEQ, OP_BNE: begin
                d_branch = 1'b1;
                d_alu    = 3'd6;
            end
            OP_LW: begin
                d_memrd    = 1'b1;
                d_memtoreg = 1'b1;
                d_regwr    = 1'b1;
                d_alusrc   = 1'b1;
                d_alu      = 3'd2;
            end
            OP_SW: begin
                d_memwr  = 1'b1;
                d_alusrc = 1'b1;
                d_alu    = 3'd2;
            end
            OP_J: begin
                d_jump = 1'b1;
            end
            OP_JAL: begin
                d_jump  = 1'b1;
                d_regwr = 1'b1;
                d_jal   = 1'b1;
            end
            default: d_ok = 1'b0;
        endcase
    end

    // A SYSCALL just released by the handler is treated as consumed
    // for one cycle, so fetch can move past it instead of re-entering.
    assign mdu_hazard = mdu_busy & instr_valid & (is_mdu | is_mf | is_sys);
    assign sys_enter  = (state == IDLE) & instr_valid & is_sys
                        & ~flush_in & ~sys_done;
    assign stall_out  = (state != IDLE) | mdu_hazard | sys_enter;
    assign take       = instr_valid & ~flush_in & ~stall_out;
    assign mdu_start  = take & is_mdu;

    // Control bundle registers, syscall FSM and MDU busy tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            EX_D          <= '0;
            MEM_D         <= '0;
            WB_D          <= '0;
            jump          <= 1'b0;
            branch        <= 1'b0;
            jr_control    <= 1'b0;
            jal_control   <= 1'b0;
            illegal_instr <= 1'b0;
            syscall_req   <= 1'b0;
            mdu_busy      <= 1'b0;
            state         <= IDLE;
            drain_cnt     <= '0;
            mdu_cnt       <= '0;
            sys_done      <= 1'b0;
        end else if (!stall_in) begin
            if (take) begin
                EX_D          <= {d_regdst, d_alusrc, ALUOP_W'(d_alu)};
                MEM_D         <= {d_memwr, d_memrd};
                WB_D          <= {d_regwr, d_memtoreg};
                jump          <= d_jump;
                branch        <= d_branch;
                jr_control    <= d_jr;
                jal_control   <= d_jal;
                illegal_instr <= ~d_ok;
            end else begin
                EX_D          <= '0;
                MEM_D         <= '0;
                WB_D          <= '0;
                jump          <= 1'b0;
                branch        <= 1'b0;
                jr_control    <= 1'b0;
                jal_control   <= 1'b0;
                illegal_instr <= 1'b0;
            end

            sys_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sys_enter && !mdu_busy) begin
                        state     <= SYS_DRAIN;
                        drain_cnt <= DCW'(DRAIN_DEPTH - 1);
                    end
                end
                SYS_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state       <= SYS_WAIT;
                        syscall_req <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                SYS_WAIT: begin
                    if (syscall_ack) begin
                        state       <= IDLE;
                        syscall_req <= 1'b0;
                        sys_done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (mdu_start) begin
                mdu_cnt  <= MCW'(MDU_LAT);
                mdu_busy <= 1'b1;
            end else if (mdu_busy) begin
                mdu_cnt <= mdu_cnt - MCW'(1);
                if (mdu_cnt == MCW'(1)) begin
                    mdu_busy <= 1'b0;
                end
            end
        end
    end

endmodule
